// File: rtl/inst_fetch_responder.sv
// Instruction-memory responder: one outstanding fetch, fixed LATENCY, with a program-load write port.
// Optional misaligned-fetch error reporting is enabled by defining INST_FETCH_MISALIGN_CHK_EN.
module inst_fetch_responder #(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned LATENCY  = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [31:0]              REQ_ADDR,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [31:0]              RSP_INST,
    output logic                     RSP_ERR,
    input  logic                     LD_EN,
    input  logic [$clog2(DEPTH)-1:0] LD_ADDR,
    input  logic [31:0]              LD_DATA,
    output logic                     BUSY,
    output logic [1:0]               FSM_STATE
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     addr_q;
    logic [31:0]     mem [DEPTH];

    logic [31:0]     smp_addr;
    logic [AW-1:0]   smp_idx;
    logic            smp_oor;
    logic            smp_mis;
    logic            smp_err;
    logic [31:0]     smp_word;

    // Load port is independent of the FSM and of RST; contents survive reset.
    always_ff @(posedge CLK) begin
        if (LD_EN) begin
            mem[LD_ADDR] <= LD_DATA;
        end
    end

    // The word is sampled from the live request when LATENCY is 1, otherwise from the latched address.
    assign smp_addr = (state == S_IDLE) ? REQ_ADDR : addr_q;
    assign smp_idx  = smp_addr[AW+1:2];
    assign smp_oor  = |smp_addr[31:AW+2];
`ifdef INST_FETCH_MISALIGN_CHK_EN
    assign smp_mis  = |smp_addr[1:0];
`else
    logic unused_low_bits;
    assign unused_low_bits = ^smp_addr[1:0];
    assign smp_mis  = 1'b0;
`endif
    assign smp_err  = smp_mis | smp_oor;
    // Write-first: a load landing on the sample edge is what gets returned.
    assign smp_word = (LD_EN && (LD_ADDR == smp_idx)) ? LD_DATA : mem[smp_idx];

    // Handshakes: a request transfers on an edge with REQ_VALID && REQ_READY; a response
    // transfers on an edge with RSP_VALID && RSP_READY, and RSP_INST/RSP_ERR hold until then.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_INST  <= '0;
            RSP_ERR   <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    REQ_READY <= 1'b1;
                    if (REQ_VALID && REQ_READY) begin
                        addr_q    <= REQ_ADDR;
                        REQ_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        if (LATENCY == 1) begin
                            state     <= S_RESP;
                            RSP_VALID <= 1'b1;
                            RSP_INST  <= smp_err ? NOP_INST : smp_word;
                            RSP_ERR   <= smp_err;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= S_RESP;
                        RSP_VALID <= 1'b1;
                        RSP_INST  <= smp_err ? NOP_INST : smp_word;
                        RSP_ERR   <= smp_err;
                    end
                end
                S_RESP: begin
                    if (RSP_READY) begin
                        state     <= S_IDLE;
                        RSP_VALID <= 1'b0;
                        REQ_READY <= 1'b1;
                        BUSY      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    RSP_VALID <= 1'b0;
                    REQ_READY <= 1'b1;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

    assign FSM_STATE = state;

endmodule
